// File: rtl/dp_issue_ctrl_pkg.sv
// Shared definitions for the data-processing issue sequencer.
// Contents: sequencer FSM state type, SHIFT_OP encodings, ARM condition
// codes and ARM data-processing opcodes (AND..MVN).
package dp_issue_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_EXEC,
      ST_WB
   } state_e;

   // SHIFT_OP = {shift type, amount-from-register}
   localparam logic [2:0] SH_LSL_IMM = 3'b000;
   localparam logic [2:0] SH_LSL_REG = 3'b001;
   localparam logic [2:0] SH_LSR_IMM = 3'b010;
   localparam logic [2:0] SH_LSR_REG = 3'b011;
   localparam logic [2:0] SH_ASR_IMM = 3'b100;
   localparam logic [2:0] SH_ASR_REG = 3'b101;
   localparam logic [2:0] SH_ROR_IMM = 3'b110;
   localparam logic [2:0] SH_ROR_REG = 3'b111;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

endpackage

// File: rtl/dp_issue_ctrl_cond.sv
// ARM condition-code evaluator.
// Ports: cond_i  - 4-bit condition field
//        nzcv_i  - {N,Z,C,V} flags
//        pass_o  - 1 when the condition holds (1111 never passes)
module dp_cond_check
   import dp_issue_ctrl_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       pass_o
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv_i;

   always_comb begin
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = z;
         COND_NE: pass_o = !z;
         COND_CS: pass_o = c;
         COND_CC: pass_o = !c;
         COND_MI: pass_o = n;
         COND_PL: pass_o = !n;
         COND_VS: pass_o = v;
         COND_VC: pass_o = !v;
         COND_HI: pass_o = c && !z;
         COND_LS: pass_o = !c || z;
         COND_GE: pass_o = (n == v);
         COND_LT: pass_o = (n != v);
         COND_GT: pass_o = !z && (n == v);
         COND_LE: pass_o = z || (n != v);
         COND_AL: pass_o = 1'b1;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/dp_issue_ctrl.sv
// Data-processing issue sequencer driving the shifter/ALU wrapper.
// Ports: clk/rst (sync, active-high); instr_valid/instr/instr_ready accept
// one instruction; nzcv and F come back from the wrapper; A, Shift_Data,
// Shift_Num, SHIFT_OP, ALU_OP are registered operands; S strobes the
// wrapper's flag latch; done/illegal retire the instruction; wr_* preload
// the 16x32 register file in IDLE; dbg_addr/dbg_data read it directly.
module dp_issue_ctrl
   import dp_issue_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic [3:0]  nzcv,
   input  logic [31:0] F,
   output logic [31:0] A,
   output logic [31:0] Shift_Data,
   output logic [7:0]  Shift_Num,
   output logic [2:0]  SHIFT_OP,
   output logic [3:0]  ALU_OP,
   output logic        S,
   output logic        done,
   output logic        illegal,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic [3:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] regs_q [16];
   logic        pass_q, pass_d;
   logic [31:0] result_q, result_d;
   logic [31:0] a_q, a_d, sd_q, sd_d;
   logic [7:0]  sn_q, sn_d;
   logic [2:0]  sop_q, sop_d;
   logic [3:0]  aop_q, aop_d;
   logic        s_q, s_d, done_q, done_d, ill_q, ill_d;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        cond_pass, is_illegal, is_test;

   dp_cond_check u_cond (
      .cond_i (instr_q[31:28]),
      .nzcv_i (nzcv),
      .pass_o (cond_pass)
   );

   // Non-DP class, or register-specified shift with bit7 set (multiply/extra load-store space)
   assign is_illegal = (instr_q[27:26] != 2'b00) || (!instr_q[25] && instr_q[4] && instr_q[7]);
   // TST/TEQ/CMP/CMN: flags only, never write Rd
   assign is_test    = (instr_q[24:23] == 2'b10);

   always_comb begin
      state_d  = state_q;
      instr_d  = instr_q;
      pass_d   = pass_q;
      result_d = result_q;
      a_d      = a_q;
      sd_d     = sd_q;
      sn_d     = sn_q;
      sop_d    = sop_q;
      aop_d    = aop_q;
      s_d      = 1'b0;
      done_d   = 1'b0;
      ill_d    = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = wr_addr;
      rf_wdata = wr_data;
      case (state_q)
         ST_IDLE: begin
            rf_we = wr_en;
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            pass_d = cond_pass;
            a_d    = regs_q[instr_q[19:16]];
            aop_d  = instr_q[24:21];
            if (instr_q[25]) begin
               sd_d  = {24'h0, instr_q[7:0]};
               sn_d  = {3'b000, instr_q[11:8], 1'b0};
               sop_d = SH_ROR_IMM;
            end else begin
               sd_d = regs_q[instr_q[3:0]];
               if (instr_q[4]) begin
                  sn_d  = regs_q[instr_q[11:8]][7:0];
                  sop_d = {instr_q[6:5], 1'b1};
               end else begin
                  sn_d  = {3'b000, instr_q[11:7]};
                  sop_d = {instr_q[6:5], 1'b0};
               end
            end
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // S/done/illegal are registered here so they are high exactly during WB
            result_d = F;
            done_d   = 1'b1;
            ill_d    = is_illegal;
            s_d      = pass_q && !is_illegal && (instr_q[20] || is_test);
            state_d  = ST_WB;
         end
         ST_WB: begin
            if (pass_q && !is_illegal && !is_test) begin
               rf_we    = 1'b1;
               rf_waddr = instr_q[15:12];
               rf_wdata = result_q;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         instr_q  <= '0;
         pass_q   <= 1'b0;
         result_q <= '0;
         a_q      <= '0;
         sd_q     <= '0;
         sn_q     <= '0;
         sop_q    <= '0;
         aop_q    <= '0;
         s_q      <= 1'b0;
         done_q   <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         instr_q  <= instr_d;
         pass_q   <= pass_d;
         result_q <= result_d;
         a_q      <= a_d;
         sd_q     <= sd_d;
         sn_q     <= sn_d;
         sop_q    <= sop_d;
         aop_q    <= aop_d;
         s_q      <= s_d;
         done_q   <= done_d;
         ill_q    <= ill_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
      end else if (rf_we) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign A           = a_q;
   assign Shift_Data  = sd_q;
   assign Shift_Num   = sn_q;
   assign SHIFT_OP    = sop_q;
   assign ALU_OP      = aop_q;
   assign S           = s_q;
   assign done        = done_q;
   assign illegal     = ill_q;
   assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Scoreboard bench for dp_issue_ctrl with a behavioural shifter/ALU wrapper.
module tb_dp_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic [3:0]  nzcv;
   logic [31:0] F;
   logic [31:0] A, Shift_Data;
   logic [7:0]  Shift_Num;
   logic [2:0]  SHIFT_OP;
   logic [3:0]  ALU_OP;
   logic        S, done, illegal;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  dbg_addr = '0;
   logic [31:0] dbg_data;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;

   dp_issue_ctrl dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .nzcv(nzcv), .F(F), .A(A),
      .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .SHIFT_OP(SHIFT_OP),
      .ALU_OP(ALU_OP), .S(S), .done(done), .illegal(illegal),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- architectural helpers ----------------
   function automatic logic [31:0] shf(input logic [31:0] v, input logic [7:0] amt, input logic [1:0] typ);
      int unsigned r;
      case (typ)
         2'd0: return (amt >= 8'd32) ? 32'h0 : (v << amt);
         2'd1: return (amt >= 8'd32) ? 32'h0 : (v >> amt);
         2'd2: return (amt >= 8'd32) ? {32{v[31]}} : 32'($signed(v) >>> amt);
         default: begin
            r = 32'(amt) % 32;
            return (r == 0) ? v : ((v >> r) | (v << (32 - r)));
         end
      endcase
   endfunction

   // returns {N,Z,C,V,result}
   function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] op, input logic [3:0] fl);
      logic [32:0] s;
      logic [31:0] f, x, y;
      logic c, v, ci, arith;
      c = fl[1]; v = fl[0]; arith = 1'b1; f = '0; x = a; y = b; ci = 1'b0;
      case (op)
         4'h0, 4'h8: begin f = a & b;  arith = 1'b0; end
         4'h1, 4'h9: begin f = a ^ b;  arith = 1'b0; end
         4'hC:       begin f = a | b;  arith = 1'b0; end
         4'hD:       begin f = b;      arith = 1'b0; end
         4'hE:       begin f = a & ~b; arith = 1'b0; end
         4'hF:       begin f = ~b;     arith = 1'b0; end
         4'h2, 4'hA: begin x = a; y = ~b; ci = 1'b1; end
         4'h3:       begin x = b; y = ~a; ci = 1'b1; end
         4'h4, 4'hB: begin x = a; y = b;  ci = 1'b0; end
         4'h5:       begin x = a; y = b;  ci = fl[1]; end
         4'h6:       begin x = a; y = ~b; ci = fl[1]; end
         default:    begin x = b; y = ~a; ci = fl[1]; end
      endcase
      if (arith) begin
         s = {1'b0, x} + {1'b0, y} + {32'h0, ci};
         f = s[31:0];
         c = s[32];
         v = (x[31] == y[31]) && (f[31] != x[31]);
      end
      return {f[31], (f == 32'h0), c, v, f};
   endfunction

   function automatic logic cpass(input logic [3:0] cnd, input logic [3:0] fl);
      logic n, z, c, v;
      {n, z, c, v} = fl;
      case (cnd)
         4'h0: return z;           4'h1: return !z;
         4'h2: return c;           4'h3: return !c;
         4'h4: return n;           4'h5: return !n;
         4'h6: return v;           4'h7: return !v;
         4'h8: return c && !z;     4'h9: return !c || z;
         4'hA: return n == v;      4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // ---------------- datapath wrapper model ----------------
   logic [35:0] wres;
   logic [3:0]  wflags;
   logic        wS_prev;
   assign wres = alu(A, shf(Shift_Data, Shift_Num, SHIFT_OP[2:1]), ALU_OP, wflags);
   assign F    = wres[31:0];
   assign nzcv = wflags;
   always @(posedge clk) begin
      if (rst) begin
         wflags  <= '0;
         wS_prev <= 1'b0;
      end else begin
         wS_prev <= S;
         if (S && !wS_prev) wflags <= wres[35:32];
      end
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic        ill;
      logic        s;
      logic [3:0]  rd;
      logic [31:0] rdval;
      logic [31:0] a;
      logic [31:0] sd;
      logic [7:0]  sn;
      logic [2:0]  so;
      logic [3:0]  aop;
      int unsigned acc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mregs [16];
   logic [3:0]  mflags = '0;
   logic        keep_valid = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_push(input logic [31:0] w, input int unsigned acc);
      exp_t        e;
      logic [35:0] r;
      logic [31:0] op2;
      logic [31:0] imm;
      logic        pass, tst;
      e.acc = acc;
      e.rd  = w[15:12];
      e.a   = mregs[w[19:16]];
      e.aop = w[24:21];
      e.ill = (w[27:26] != 2'b00) || (!w[25] && w[4] && w[7]);
      if (w[25]) begin
         imm  = {24'h0, w[7:0]};
         e.sd = imm;
         e.sn = {3'b000, w[11:8], 1'b0};
         e.so = 3'b110;
         op2  = shf(imm, 8'(2 * w[11:8]), 2'd3);
      end else begin
         e.sd = mregs[w[3:0]];
         e.sn = w[4] ? mregs[w[11:8]][7:0] : {3'b000, w[11:7]};
         e.so = {w[6:5], w[4]};
         op2  = shf(e.sd, e.sn, w[6:5]);
      end
      pass = cpass(w[31:28], mflags);
      tst  = (w[24:23] == 2'b10);
      r    = alu(e.a, op2, e.aop, mflags);
      e.s  = pass && !e.ill && (w[20] || tst);
      if (pass && !e.ill && !tst) mregs[e.rd] = r[31:0];
      e.rdval = mregs[e.rd];
      if (e.s) mflags = r[35:32];
      q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic        chk_pend = 1'b0;
   logic [31:0] chk_val = '0;
   logic        s_prev_m = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         chk_pend = 1'b0;
      end else begin
         if (chk_pend) begin
            check($sformatf("regfile_R%0d", dbg_addr), dbg_data, chk_val);
            chk_pend = 1'b0;
         end
         if (S) begin
            check("S_only_with_done", {31'h0, done}, 32'h1);
            check("S_not_consecutive", {31'h0, s_prev_m}, 32'h0);
         end
         if (done) begin
            if (q.size() == 0) begin
               check("unexpected_done", 32'h1, 32'h0);
            end else begin
               e = q.pop_front();
               check("latency", cyc, e.acc + 3);
               check("illegal", {31'h0, illegal}, {31'h0, e.ill});
               check("S", {31'h0, S}, {31'h0, e.s});
               if (!e.ill) begin
                  check("A", A, e.a);
                  check("Shift_Data", Shift_Data, e.sd);
                  check("Shift_Num", {24'h0, Shift_Num}, {24'h0, e.sn});
                  check("SHIFT_OP", {29'h0, SHIFT_OP}, {29'h0, e.so});
                  check("ALU_OP", {28'h0, ALU_OP}, {28'h0, e.aop});
               end
               dbg_addr = e.rd;
               chk_val  = e.rdval;
               chk_pend = 1'b1;
            end
         end
      end
      s_prev_m = S;
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready();
      int unsigned n = 0;
      while (!instr_ready) begin
         if (n == 20) begin
            check("ready_timeout", 32'h0, 32'h1);
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic preload(input logic [3:0] a, input logic [31:0] d);
      wait_ready();
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      mregs[a] = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic issue(input logic [31:0] w, input logic pre, input logic [3:0] pa,
                        input logic [31:0] pd, input logic stray, output int unsigned acc);
      instr_valid = 1'b1; instr = w;
      wr_en = pre; wr_addr = pa; wr_data = pd;
      wait_ready();
      if (pre) mregs[pa] = pd;
      acc = cyc;
      model_push(w, acc);
      @(negedge clk);
      instr = $urandom;
      wr_en = 1'b0;
      if (!keep_valid) instr_valid = 1'b0;
      if (stray) begin
         // preload attempts while busy must be ignored
         wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = $urandom;
         @(negedge clk);
         wr_en = 1'b0;
      end
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (q.size() != 0 || chk_pend || !instr_ready) begin
         if (n == 40) begin
            check("drain_timeout", 32'h0, 32'h1);
            return;
         end
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int unsigned acc, prev;
      logic [31:0] w;
      logic [31:0] dir [8];
      for (int i = 0; i < 16; i++) mregs[i] = '0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'h0, instr_ready}, 32'h1);
      check("rst_S", {31'h0, S}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_illegal", {31'h0, illegal}, 32'h0);
      check("rst_A", A, 32'h0);
      check("rst_Shift_Data", Shift_Data, 32'h0);
      check("rst_Shift_Num", {24'h0, Shift_Num}, 32'h0);
      check("rst_SHIFT_OP", {29'h0, SHIFT_OP}, 32'h0);
      check("rst_ALU_OP", {28'h0, ALU_OP}, 32'h0);

      // directed scenarios
      preload(4'd1, 32'd5); preload(4'd2, 32'd3);
      issue(32'hE0910002, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // ADDS R0,R1,R2
      preload(4'd1, 32'h80000000);
      issue(32'hE1B03FA1, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // MOVS R3,R1,LSR #31
      preload(4'd1, 32'd7);
      issue(32'hE1510001, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // CMP R1,R1
      issue(32'h12814001, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // ADDNE R4,R1,#1
      issue(32'hE28154FF, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // ADD R5,R1,#0xFF,ROR 8
      preload(4'd2, 32'd36);
      issue(32'hE1A06211, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // MOV R6,R1,LSL R2
      issue(32'hE5910000, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // LDR -> illegal
      issue(32'hE0817002, 1'b1, 4'd2, 32'd100, 1'b0, acc); // ADD R7,R1,R2 with same-cycle preload of R2
      issue(32'hE1A08009, 1'b0, 4'd0, 32'h0, 1'b1, acc);   // MOV R8,R9 with stray busy write
      drain();

      // back-to-back with instr_valid held high
      dir[0] = 32'hE0900001; dir[1] = 32'hE2411001; dir[2] = 32'hE1A02081;
      dir[3] = 32'hE0333004; dir[4] = 32'h00854006; dir[5] = 32'hE1A0A0C1;
      dir[6] = 32'hE3570007; dir[7] = 32'hC2866010;
      keep_valid = 1'b1;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         issue(dir[i], 1'b0, 4'd0, 32'h0, 1'b0, acc);
         if (i > 0) check("throughput", acc - prev, 32'd4);
         prev = acc;
      end
      keep_valid  = 1'b0;
      instr_valid = 1'b0;
      drain();

      // randomized traffic
      for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
      for (int i = 0; i < 150; i++) begin
         w = $urandom;
         if ($urandom_range(0, 1) == 0) w[31:28] = 4'hE;
         if ($urandom_range(0, 9) != 0) w[27:26] = 2'b00;
         if (!w[25] && w[4] && $urandom_range(0, 3) != 0) w[7] = 1'b0;
         issue(w, ($urandom_range(0, 5) == 0), 4'($urandom), $urandom,
               ($urandom_range(0, 5) == 0), acc);
      end
      drain();

      // reset during EXEC aborts the instruction
      instr_valid = 1'b1; instr = 32'hE0910002;
      wait_ready();
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      mflags = '0;
      check("abort_ready", {31'h0, instr_ready}, 32'h1);
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_S", {31'h0, S}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         check("abort_quiet", {30'h0, S, done}, 32'h0);
      end
      preload(4'd1, 32'd11);
      issue(32'hE0910002, 1'b0, 4'd0, 32'h0, 1'b0, acc);   // ADDS R0,R1,R2 after reset
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dp_issue_ctrl.md
# dp_issue_ctrl

Data-processing issue sequencer: the initiator side of the shifter/ALU datapath wrapper. Accepts one 32-bit ARM data-processing instruction via valid/ready, checks its condition against the wrapper's NZCV flags, and reads operands from an internal 16×32 register file. It then drives A/Shift_Data/Shift_Num/SHIFT_OP/ALU_OP, pulses S for flag update, and writes F back to Rd.

## Interface
- No parameters; widths fixed: 32-bit data, 16 registers.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word
- instr_ready  out  1  high only in IDLE
- nzcv  in  4  {N,Z,C,V} from datapath wrapper
- F  in  32  ALU result (combinational from driven operands)
- A, Shift_Data  out  32  ALU operand A = R[Rn]; shifter input
- Shift_Num  out  8  shift amount
- SHIFT_OP  out  3  000/001 LSL imm/reg, 010/011 LSR, 100/101 ASR, 110/111 ROR
- ALU_OP  out  4  = instr[24:21]
- S  out  1  one-cycle flag-latch strobe (wrapper latches on its rising edge)
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  qualifies done: instr[27:26]≠00 or reg-shift with bit7=1
- wr_en, wr_addr[3:0], wr_data[32]  in  preload port, honoured in IDLE only
- dbg_addr[3:0] in, dbg_data[32] out  combinational register-file read

## Operation
- FSM: IDLE → DECODE → EXEC → WB → IDLE. A handshake in IDLE (instr_valid & instr_ready) captures instr.
- DECODE: cond test on nzcv; drive operand outputs (registered) for EXEC.
  - cond: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 treated as never.
  - I=1: Shift_Data={24'b0,imm8}, Shift_Num={3'b0,rot,1'b0}, SHIFT_OP=110.
  - I=0, bit4=0: Shift_Data=R[Rm], Shift_Num={3'b0,instr[11:7]}, SHIFT_OP={instr[6:5],1'b0}.
  - I=0, bit4=1, bit7=0: Shift_Num=R[Rs][7:0], SHIFT_OP={instr[6:5],1'b1}.
- EXEC: capture F into result register; outputs held stable all cycle.
- WB: if pass & !illegal:
  - opcode 10xx (TST/TEQ/CMP/CMN): no register write; otherwise R[Rd]←result.
  - S asserted this cycle iff instr[20]=1. S is forced high for opcode 10xx even if instr[20]=0.
  - done=1. Condition fail: no write, no S, done=1, illegal=0.
- Illegal: no write, no S, done=1 with illegal=1.
- R15 is an ordinary register; no PC semantics.

## Timing
- Reset values: state IDLE, instr_ready=1 after reset cycle, S=0, done=0, illegal=0, A=Shift_Data=0, Shift_Num=0, SHIFT_OP=0, ALU_OP=0, all registers 0.
- Latency: accept at edge k → done/S high during cycle k+3. Throughput: one instruction per 4 cycles.
- S is a registered output, low in every state except WB, and never high two consecutive cycles.
- Flags consumed in DECODE must reflect the prior instruction's S; the 1-cycle IDLE gap guarantees this.
- wr_en outside IDLE is ignored. A preload write and a handshake in the same IDLE cycle are both performed. DECODE sees the new value when Rn/Rm/Rs = wr_addr.
- WB write with Rd = dbg_addr: dbg_data updates the next cycle.
- rst mid-instruction: abort, no write, no S, no done, return to IDLE next cycle.
- instr_valid ignored outside IDLE; instr may change freely after handshake.

## Structure
- Shared package: SHIFT_OP encodings, cond codes, ALU opcode constants (AND..MVN), FSM state enum.
- One natural sub-module: dp_cond_check (4-bit cond, nzcv → pass), reused later by branch logic.
- Register file inline (16×32 flops, 2 write sources muxed by state).

## Test plan
- Preload R1=5, R2=3; ADDS R0,R1,R2 (0xE0910002) → done at accept+3, R0=8, S pulsed once, ALU_OP=0100, SHIFT_OP=000, Shift_Num=0.
- Preload R1=0x80000000. MOVS R3,R1,LSR #31 (0xE1B03FA1) → SHIFT_OP=010, Shift_Num=31, R3=1.
- CMP R1,R1 (0xE1510001) with R1=7 → no register write, S pulsed; then ADDNE R4,R1,#1 (0x12814001) → done, R4 unchanged. nzcv must carry Z=1 into the second instruction's DECODE.
- ADD R5,R1,#0xFF,ROR 8 (0xE28154FF) → Shift_Data=0xFF, Shift_Num=8, SHIFT_OP=110.
- Reg shift with R2=36: MOV R6,R1,LSL R2 (0xE1A06211) → Shift_Num=36, SHIFT_OP=001. Word 0xE5910000 (LDR) → done with illegal=1, no write.
- Assert rst in EXEC of ADDS → no write, no S, no done, instr_ready=1 next-next cycle. Also hold instr_valid continuously → exactly one accept per 4 cycles.
